pipe_hazard_ctrl: RTL and testbench

- Hazard scheduler for the 4-stage pipelined register-file datapath (IF, ID, EXE, WB).
- Tracks the destination registers of instructions in flight in EXE and WB, and compares them against the source registers of the instruction currently in ID.
- On a read-after-write conflict it either stalls IF/ID and injects a bubble into ID/EXE, or (with the optional feature) drives registered forward selects for the EXE operand muxes.
- Sits beside the ID/EXE and EXE/WB pipeline registers; drives their enables and muxes.

---
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundles the ID-stage instruction description presented to the hazard
//   scheduler together with the hazard controls it returns.
//
//   master : pipeline side. Drives freeze and the ID fields, and receives
//            stall/bubble/fwd_a/fwd_b/stall_cnt.
//   slave  : hazard scheduler side. Mirror image of master.
//
//   Signals
//     freeze       external hold of all scheduler state
//     id_valid     ID holds a real instruction
//     id_rs1/2     ID source registers
//     id_rs1/2_used  source is actually read by the ID instruction
//     id_wen       ID instruction writes the register file
//     id_waddr     ID destination register
//     stall        hold PC and IF/ID (combinational)
//     bubble       load a NOP into ID/EXE (combinational)
//     fwd_a/fwd_b  EXE operand takes aluout_EXE_WB (registered)
//     stall_cnt    saturating count of stall cycles
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             id_valid;
  logic [AW-1:0]    id_rs1;
  logic [AW-1:0]    id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_wen;
  logic [AW-1:0]    id_waddr;
  logic             stall;
  logic             bubble;
  logic             fwd_a;
  logic             fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output freeze, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_wen, id_waddr,
    input  stall, bubble, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  freeze, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_wen, id_waddr,
    output stall, bubble, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Read-after-write hazard scheduler for a 4-stage IF/ID/EXE/WB pipeline.
//   It shadows the destination registers held in ID/EXE (exe slot) and
//   EXE/WB (wb slot) and compares them against the sources of the ID
//   instruction. A conflict stalls IF/ID and injects a bubble into ID/EXE,
//   or, when HAZ_FWD_EN is defined, an exe-slot conflict is resolved by a
//   registered forward select on the EXE operand muxes instead.
//
//   Optional feature macro: HAZ_FWD_EN (undefined -> fwd_a/fwd_b tied low).
//
//   Ports
//     clk   pipeline clock, rising edge
//     rst   asynchronous reset, active-low
//     hz    pipe_hazard_ctrl_if.slave (ID fields, freeze, hazard outputs)
//
//   Parameters
//     AW          register address width
//     REGFILE_WT  1 = WB write visible to an ID read in the same cycle
//     ZERO_REG    1 = register 0 is hardwired zero, never a hazard
//     CNT_W       stall counter width
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int AW         = 5,
  parameter int REGFILE_WT = 0,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  // A producer sitting in WB only blocks a reader when the register file
  // does not bypass its own write port.
  localparam logic WB_BLOCKS = (REGFILE_WT == 0);
  localparam logic ZR        = (ZERO_REG != 0);

  function automatic logic src_live(input logic vld, input logic used,
                                    input logic [AW-1:0] r);
    return vld & used & ~(ZR & (r == '0));
  endfunction

  function automatic logic dst_live(input logic vld, input logic wen,
                                    input logic [AW-1:0] r);
    return vld & wen & ~(ZR & (r == '0));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             ex_v_p1;
  logic [AW-1:0]    ex_addr_p1;
  logic             wb_v_p2;
  logic [AW-1:0]    wb_addr_p2;
  logic [CNT_W-1:0] stall_cnt_p1;

  logic rs1_live;
  logic rs2_live;
  logic m_ex1;
  logic m_ex2;
  logic m_wb1;
  logic m_wb2;
  logic stall_c;

  // ---- ID compare against exe/wb slots ----
  always_comb begin
    rs1_live = src_live(hz.id_valid, hz.id_rs1_used, hz.id_rs1);
    rs2_live = src_live(hz.id_valid, hz.id_rs2_used, hz.id_rs2);
    m_ex1    = rs1_live & ex_v_p1 & (hz.id_rs1 == ex_addr_p1);
    m_ex2    = rs2_live & ex_v_p1 & (hz.id_rs2 == ex_addr_p1);
    m_wb1    = rs1_live & wb_v_p2 & (hz.id_rs1 == wb_addr_p2);
    m_wb2    = rs2_live & wb_v_p2 & (hz.id_rs2 == wb_addr_p2);
  end

`ifdef HAZ_FWD_EN
  logic fwd_a_p1;
  logic fwd_b_p1;
  logic haz1;
  logic haz2;

  // The exe-slot producer is the most recent writer, so its forward wins
  // over an older wb-slot copy of the same register.
  always_comb begin
    haz1    = WB_BLOCKS & m_wb1 & ~m_ex1;
    haz2    = WB_BLOCKS & m_wb2 & ~m_ex2;
    stall_c = haz1 | haz2;
  end

  // ---- forward select, valid while the consumer sits in EXE ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_p1 <= 1'b0;
      fwd_b_p1 <= 1'b0;
    end else if (!hz.freeze) begin
      fwd_a_p1 <= m_ex1 & ~stall_c;
      fwd_b_p1 <= m_ex2 & ~stall_c;
    end
  end

  assign hz.fwd_a = fwd_a_p1;
  assign hz.fwd_b = fwd_b_p1;
`else
  assign stall_c  = m_ex1 | m_ex2 | (WB_BLOCKS & (m_wb1 | m_wb2));
  assign hz.fwd_a = 1'b0;
  assign hz.fwd_b = 1'b0;
`endif

  // ---- slot valids and stall counter (ID -> EXE -> WB) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v_p1      <= 1'b0;
      wb_v_p2      <= 1'b0;
      stall_cnt_p1 <= '0;
    end else if (!hz.freeze) begin
      wb_v_p2 <= ex_v_p1;
      ex_v_p1 <= ~stall_c & dst_live(hz.id_valid, hz.id_wen, hz.id_waddr);
      if (stall_c) begin
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      end
    end
  end

  // ---- slot addresses; only meaningful when the matching valid is set ----
  always_ff @(posedge clk) begin
    if (!hz.freeze) begin
      wb_addr_p2 <= ex_addr_p1;
      ex_addr_p1 <= hz.id_waddr;
    end
  end

  assign hz.stall     = stall_c;
  assign hz.bubble    = stall_c & ~hz.freeze;
  assign hz.stall_cnt = stall_cnt_p1;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two schedulers run side by side: dut0 (REGFILE_WT=0, 4-bit counter so
//   saturation is reachable) and dut1 (REGFILE_WT=1, 16-bit counter). Each is
//   fed from its own instruction queue; the ID instruction advances when the
//   reference model says it is not stalled. The model tracks, per register,
//   the cycle its latest writer left ID and derives readiness from that.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic       u1;
    logic [4:0] r1;
    logic       u2;
    logic [4:0] r2;
    logic       w;
    logic [4:0] wd;
  } instr_t;

  localparam instr_t NOP = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frz = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.AW(AW), .CNT_W(4))  hz0 ();
  pipe_hazard_ctrl_if #(.AW(AW), .CNT_W(16)) hz1 ();

  instr_t cur [2];
  instr_t q0 [$];
  instr_t q1 [$];

  assign hz0.freeze      = frz;
  assign hz0.id_valid    = cur[0].v;
  assign hz0.id_rs1      = cur[0].r1;
  assign hz0.id_rs2      = cur[0].r2;
  assign hz0.id_rs1_used = cur[0].u1;
  assign hz0.id_rs2_used = cur[0].u2;
  assign hz0.id_wen      = cur[0].w;
  assign hz0.id_waddr    = cur[0].wd;
  assign hz1.freeze      = frz;
  assign hz1.id_valid    = cur[1].v;
  assign hz1.id_rs1      = cur[1].r1;
  assign hz1.id_rs2      = cur[1].r2;
  assign hz1.id_rs1_used = cur[1].u1;
  assign hz1.id_rs2_used = cur[1].u2;
  assign hz1.id_wen      = cur[1].w;
  assign hz1.id_waddr    = cur[1].wd;

  pipe_hazard_ctrl #(.AW(AW), .REGFILE_WT(0), .ZERO_REG(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .hz(hz0.slave));
  pipe_hazard_ctrl #(.AW(AW), .REGFILE_WT(1), .ZERO_REG(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .hz(hz1.slave));

  int   n_total = 0;
  int   n_bad   = 0;
  int   k   [2];
  int   iss [2][32];
  logic efa [2];
  logic efb [2];
  int   ecnt[2];
  int   nst [2];
  int   nbb [2];
  int   nfa [2];
  int   nfb [2];

  // ---------------- reference model ----------------
  function automatic int cmax(int m);
    return (m == 0) ? 15 : 65535;
  endfunction

  // Cycles after leaving ID until a reader in ID sees the value in the file.
  function automatic int lat(int m);
    return (m == 0) ? 3 : 2;
  endfunction

  function automatic bit live(int m, logic used, logic [4:0] r);
    return cur[m].v && used && (r != 0);
  endfunction

  function automatic bit src_fw(int m, logic used, logic [4:0] r);
    return FWD && live(m, used, r) && (k[m] == iss[m][r] + 1);
  endfunction

  function automatic bit src_hz(int m, logic used, logic [4:0] r);
    if (!live(m, used, r)) return 1'b0;
    if (k[m] >= iss[m][r] + lat(m)) return 1'b0;
    if (src_fw(m, used, r)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall(int m);
    return src_hz(m, cur[m].u1, cur[m].r1) || src_hz(m, cur[m].u2, cur[m].r2);
  endfunction

  function automatic instr_t mk(logic v, logic u1, logic [4:0] r1, logic u2,
                                logic [4:0] r2, logic w, logic [4:0] wd);
    instr_t i;
    i.v = v; i.u1 = u1; i.r1 = r1; i.u2 = u2; i.r2 = r2; i.w = w; i.wd = wd;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    return mk(logic'($urandom_range(3) != 0), logic'($urandom_range(1)),
              5'($urandom_range(7)), logic'($urandom_range(1)),
              5'($urandom_range(7)), logic'($urandom_range(1)),
              5'($urandom_range(7)));
  endfunction

  task automatic load_cur();
    cur[0] = (q0.size() != 0) ? q0[0] : NOP;
    cur[1] = (q1.size() != 0) ? q1[0] : NOP;
  endtask

  task automatic push2(instr_t i);
    q0.push_back(i);
    q1.push_back(i);
    load_cur();
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 32; r++) iss[m][r] = -100;
      efa[m]  = 1'b0;
      efb[m]  = 1'b0;
      ecnt[m] = 0;
    end
  endtask

  task automatic model_edge();
    bit s, fa, fb;
    if (!rst || frz) return;
    for (int m = 0; m < 2; m++) begin
      s  = exp_stall(m);
      fa = src_fw(m, cur[m].u1, cur[m].r1);
      fb = src_fw(m, cur[m].u2, cur[m].r2);
      if (cur[m].v && cur[m].w && cur[m].wd != 0 && !s) iss[m][cur[m].wd] = k[m];
      efa[m] = fa && !s;
      efb[m] = fb && !s;
      if (s && ecnt[m] < cmax(m)) ecnt[m]++;
      if (!s) begin
        if (m == 0 && q0.size() != 0) void'(q0.pop_front());
        if (m == 1 && q1.size() != 0) void'(q1.pop_front());
      end
      k[m]++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(int m, logic st, logic bb, logic fa, logic fb,
                           logic [31:0] sc);
    bit es;
    es = exp_stall(m);
    check_val($sformatf("d%0d_stall", m),  32'(st), 32'(es));
    check_val($sformatf("d%0d_bubble", m), 32'(bb), 32'(es && !frz));
    check_val($sformatf("d%0d_fwd_a", m),  32'(fa), 32'(efa[m]));
    check_val($sformatf("d%0d_fwd_b", m),  32'(fb), 32'(efb[m]));
    check_val($sformatf("d%0d_cnt", m),    sc,      32'(ecnt[m]));
    if (st === 1'b1) nst[m]++;
    if (bb === 1'b1) nbb[m]++;
    if (fa === 1'b1) nfa[m]++;
    if (fb === 1'b1) nfb[m]++;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_dut(0, hz0.stall, hz0.bubble, hz0.fwd_a, hz0.fwd_b, 32'(hz0.stall_cnt));
    check_dut(1, hz1.stall, hz1.bubble, hz1.fwd_a, hz1.fwd_b, 32'(hz1.stall_cnt));
    @(posedge clk);
    model_edge();
    #1;
    load_cur();
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic clr();
    for (int m = 0; m < 2; m++) begin
      nst[m] = 0; nbb[m] = 0; nfa[m] = 0; nfb[m] = 0;
    end
  endtask

  task automatic do_reset();
    frz = 1'b0;
    rst = 1'b0;
    model_reset();
    q0.delete();
    q1.delete();
    load_cur();
    run(2);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int m = 0; m < 2; m++) k[m] = 0;
    model_reset();
    load_cur();
    #1 rst = 1'b0;

    // reset with a reader of r3 in ID
    push2(mk(1, 1, 5'd3, 0, 5'd0, 0, 5'd0));
    cyc();
    check_val("rst_stall",  32'(hz0.stall),     32'd0);
    check_val("rst_bubble", 32'(hz0.bubble),    32'd0);
    check_val("rst_fwd_a",  32'(hz0.fwd_a),     32'd0);
    check_val("rst_cnt",    32'(hz0.stall_cnt), 32'd0);
    rst = 1'b1;
    run(3);

    // back-to-back RAW on r5 via rs1
    do_reset();
    push2(mk(1, 0, 5'd0, 0, 5'd0, 1, 5'd5));
    push2(mk(1, 1, 5'd5, 0, 5'd0, 0, 5'd0));
    clr();
    run(6);
    check_val("b2b_stalls0",  32'(nst[0]), FWD ? 32'd0 : 32'd2);
    check_val("b2b_bubbles0", 32'(nbb[0]), FWD ? 32'd0 : 32'd2);
    check_val("b2b_fwd_a0",   32'(nfa[0]), FWD ? 32'd1 : 32'd0);
    check_val("b2b_cnt0",     32'(hz0.stall_cnt), FWD ? 32'd0 : 32'd2);
    check_val("b2b_stalls1",  32'(nst[1]), FWD ? 32'd0 : 32'd1);
    check_val("b2b_fwd_a1",   32'(nfa[1]), FWD ? 32'd1 : 32'd0);

    // distance-2 RAW on r7 via rs2
    do_reset();
    push2(mk(1, 0, 5'd0, 0, 5'd0, 1, 5'd7));
    push2(mk(1, 0, 5'd0, 0, 5'd0, 0, 5'd0));
    push2(mk(1, 0, 5'd0, 1, 5'd7, 0, 5'd0));
    clr();
    run(6);
    check_val("d2_stalls0", 32'(nst[0]), 32'd1);
    check_val("d2_stalls1", 32'(nst[1]), 32'd0);
    check_val("d2_fwd_b0",  32'(nfb[0]), 32'd0);

    // r0 writer/reader and an unused rs2
    do_reset();
    push2(mk(1, 0, 5'd0, 0, 5'd0, 1, 5'd0));
    push2(mk(1, 1, 5'd0, 0, 5'd0, 0, 5'd0));
    push2(mk(1, 0, 5'd0, 0, 5'd0, 1, 5'd9));
    push2(mk(1, 0, 5'd0, 0, 5'd9, 0, 5'd0));
    clr();
    run(7);
    check_val("zero_unused_stalls0", 32'(nst[0]), 32'd0);
    check_val("zero_unused_stalls1", 32'(nst[1]), 32'd0);

    // freeze in the middle of a stall
    do_reset();
    push2(mk(1, 0, 5'd0, 0, 5'd0, 1, 5'd5));
    push2(mk(1, 1, 5'd5, 0, 5'd0, 0, 5'd0));
    run(2);
    frz = 1'b1;
    clr();
    run(3);
    check_val("frz_bubbles0", 32'(nbb[0]), 32'd0);
    check_val("frz_stalls0",  32'(nst[0]), FWD ? 32'd0 : 32'd3);
    check_val("frz_cnt0",     32'(hz0.stall_cnt), FWD ? 32'd0 : 32'd1);
    frz = 1'b0;
    clr();
    run(5);
    check_val("unfrz_stalls0", 32'(nst[0]), FWD ? 32'd0 : 32'd1);
    check_val("unfrz_cnt0",    32'(hz0.stall_cnt), FWD ? 32'd0 : 32'd2);

    // reset while a distance-2 stall is pending
    do_reset();
    push2(mk(1, 0, 5'd0, 0, 5'd0, 1, 5'd7));
    push2(mk(1, 0, 5'd0, 0, 5'd0, 0, 5'd0));
    push2(mk(1, 0, 5'd0, 1, 5'd7, 0, 5'd0));
    run(2);
    rst = 1'b0;
    model_reset();
    #1;
    check_val("rst_mid_stall0", 32'(hz0.stall),     32'd0);
    check_val("rst_mid_cnt0",   32'(hz0.stall_cnt), 32'd0);
    run(1);
    rst = 1'b1;
    run(4);

    // counter saturation on the 4-bit counter
    do_reset();
    repeat (20) begin
      push2(mk(1, 0, 5'd0, 0, 5'd0, 1, 5'd7));
      push2(mk(1, 0, 5'd0, 0, 5'd0, 0, 5'd0));
      push2(mk(1, 0, 5'd0, 1, 5'd7, 0, 5'd0));
    end
    run(100);
    check_val("sat_cnt0", 32'(hz0.stall_cnt), 32'd15);
    check_val("sat_cnt1", 32'(hz1.stall_cnt), 32'd0);

    // randomized traffic with freezes and occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 2) q0.push_back(rnd_instr());
      if (q1.size() < 2) q1.push_back(rnd_instr());
      load_cur();
      frz = ($urandom_range(7) == 0);
      if ($urandom_range(299) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      cyc();
    end
    frz = 1'b0;
    rst = 1'b1;
    run(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
